// File: rtl/mux8x1_rr_arbiter.sv
// Round-robin arbiter that shares one mux8x1 datapath among 8 requesters.
// Registered one-hot grant and select, one dead cycle between owners, bounded hold when contended.
module mux8x1_rr_arbiter #(
  parameter int unsigned MAX_HOLD  = 16,
  parameter int unsigned CNT_WIDTH = $clog2(MAX_HOLD) + 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] select,
  output logic       sel_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    GAP  = 2'b10
  } state_t;

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(MAX_HOLD - 1);

  state_t               state, state_n;
  logic [2:0]           ptr, ptr_n;
  logic [CNT_WIDTH-1:0] hold_cnt, hold_cnt_n;
  logic [7:0]           grant_n;
  logic [2:0]           select_n;
  logic                 found;
  logic [2:0]           winner;
  logic [2:0]           idx;
  logic                 release_c;

  // Rotating priority search starting at ptr
  always_comb begin
    found  = 1'b0;
    winner = 3'd0;
    idx    = 3'd0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Owner lets go when its request drops, or at the hold limit while someone else waits
  assign release_c = !req[select] || ((hold_cnt == HOLD_LAST) && |(req & ~grant));

  always_comb begin
    state_n    = IDLE;
    grant_n    = 8'h00;
    select_n   = select;
    ptr_n      = ptr;
    hold_cnt_n = '0;
    case (state)
      IDLE, GAP: begin
        if (enable && found) begin
          state_n  = BUSY;
          grant_n  = 8'h01 << winner;
          select_n = winner;
        end
      end
      BUSY: begin
        if (release_c) begin
          state_n = GAP;
          ptr_n   = select + 3'd1;
        end else begin
          state_n    = BUSY;
          grant_n    = grant;
          hold_cnt_n = (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_n  = IDLE;
        select_n = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      hold_cnt  <= '0;
      grant     <= 8'h00;
      select    <= 3'd0;
      sel_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_cnt_n;
      grant     <= grant_n;
      select    <= select_n;
      sel_valid <= |grant_n;
      busy      <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_mux8x1_rr_arbiter.sv
// Directed bench for mux8x1_rr_arbiter: vector table on a MAX_HOLD=16 instance
// plus hand sequences for hold-limit rotation and wrap on a MAX_HOLD=4 instance.
module tb_mux8x1_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] req;
  logic [7:0] grant, grant4;
  logic [2:0] select, select4;
  logic       sel_valid, sel_valid4;
  logic       busy, busy4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux8x1_rr_arbiter #(.MAX_HOLD(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req),
    .grant(grant), .select(select), .sel_valid(sel_valid), .busy(busy)
  );

  mux8x1_rr_arbiter #(.MAX_HOLD(4), .CNT_WIDTH(3)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .req(req),
    .grant(grant4), .select(select4), .sel_valid(sel_valid4), .busy(busy4)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] rq;
    logic [7:0] g;
    logic [2:0] s;
    logic       v;
    logic       b;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic en, input logic [7:0] rq,
                     input logic [7:0] g, input logic [2:0] s, input logic v, input logic b);
    vec_t e;
    e.rst = rst; e.en = en; e.rq = rq; e.g = g; e.s = s; e.v = v; e.b = b;
    tbl.push_back(e);
  endtask

  task automatic chk(input string nm, input int n, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, n, act, exp);
    end
  endtask

  // Apply inputs, let one rising edge sample them, then look just after it
  task automatic step(input logic rst, input logic en, input logic [7:0] rq);
    reset  = rst;
    enable = en;
    req    = rq;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    req    = 8'h00;

    // reset state and single requester held
    add(1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1);
    add(1'b0, 1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1);
    add(1'b0, 1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1);
    add(1'b0, 1'b1, 8'h00, 8'h00, 3'd2, 1'b0, 1'b1);
    add(1'b0, 1'b1, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0);
    // ptr=0, req 81: owner 0, drop, dead cycle, then owner 7
    add(1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h81, 8'h01, 3'd0, 1'b1, 1'b1);
    add(1'b0, 1'b1, 8'h80, 8'h00, 3'd0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 8'h80, 8'h80, 3'd7, 1'b1, 1'b1);
    add(1'b0, 1'b1, 8'h80, 8'h80, 3'd7, 1'b1, 1'b1);
    // enable gating: no new grant while low, no preemption in BUSY, GAP falls to IDLE
    add(1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h10, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h10, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h10, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h10, 8'h10, 3'd4, 1'b1, 1'b1);
    add(1'b0, 1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 1'b1);
    add(1'b0, 1'b0, 8'h00, 8'h00, 3'd4, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'h10, 8'h00, 3'd4, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h10, 8'h10, 3'd4, 1'b1, 1'b1);
    // reset mid-grant of requester 5, then re-arbitration from ptr=0
    add(1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h20, 8'h20, 3'd5, 1'b1, 1'b1);
    add(1'b0, 1'b1, 8'h20, 8'h20, 3'd5, 1'b1, 1'b1);
    add(1'b1, 1'b1, 8'h20, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h21, 8'h01, 3'd0, 1'b1, 1'b1);
    // former owner re-requesting in GAP loses to requester 5
    add(1'b0, 1'b1, 8'h20, 8'h00, 3'd0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 8'h21, 8'h20, 3'd5, 1'b1, 1'b1);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].rq);
      chk("vec_grant", i, grant, tbl[i].g);
      chk("vec_select", i, 8'(select), 8'(tbl[i].s));
      chk("vec_valid", i, 8'(sel_valid), 8'(tbl[i].v));
      chk("vec_busy", i, 8'(busy), 8'(tbl[i].b));
    end

    // MAX_HOLD=4, all requesting: 4 cycles per owner, 1 dead cycle, owners 0..7 then 0
    step(1'b1, 1'b1, 8'h00);
    for (int o = 0; o < 9; o++) begin
      for (int c = 0; c < 4; c++) begin
        step(1'b0, 1'b1, 8'hFF);
        chk("rr4_grant", o * 5 + c, grant4, 8'h01 << (o % 8));
        chk("rr4_select", o * 5 + c, 8'(select4), 8'(o % 8));
      end
      step(1'b0, 1'b1, 8'hFF);
      chk("rr4_gap", o * 5 + 4, grant4, 8'h00);
      chk("rr4_gap_valid", o * 5 + 4, 8'(sel_valid4), 8'h00);
    end

    // MAX_HOLD=16 with contention: owner 0 for 16 cycles, gap, then owner 1
    step(1'b1, 1'b1, 8'h00);
    for (int c = 0; c < 16; c++) begin
      step(1'b0, 1'b1, 8'hFF);
      chk("rr16_hold", c, grant, 8'h01);
    end
    step(1'b0, 1'b1, 8'hFF);
    chk("rr16_gap", 16, grant, 8'h00);
    step(1'b0, 1'b1, 8'hFF);
    chk("rr16_next", 17, grant, 8'h02);

    // lone requester never loses the grant; hold counter wraps silently
    step(1'b1, 1'b1, 8'h00);
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 1'b1, 8'h08);
      chk("solo16_grant", c, grant, 8'h08);
      chk("solo4_grant", c, grant4, 8'h08);
    end

    // req drop coinciding with hold limit: single release, ptr advances by one only
    step(1'b1, 1'b1, 8'h00);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b1, 8'h03);
      chk("dual_hold", c, grant4, 8'h01);
    end
    step(1'b0, 1'b1, 8'h02);
    chk("dual_gap", 4, grant4, 8'h00);
    step(1'b0, 1'b1, 8'h03);
    chk("dual_next", 5, grant4, 8'h02);
    chk("dual_next_sel", 5, 8'(select4), 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
